// File: rtl/game_tick_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_tick_pkg
//  Brief    : Shared state encoding and effective-period helper for the
//             dodge-game tick scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package game_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int LEVEL_W   = 3;
    localparam int MAX_CNT_W = 32;

    // Period shrinks by one eighth of base per level; never below 1 when enabled.
    function automatic logic [MAX_CNT_W-1:0] eff_period(
        input logic [MAX_CNT_W-1:0] base,
        input logic [LEVEL_W-1:0]   lvl
    );
        logic [MAX_CNT_W+2:0] w_ext;
        logic [MAX_CNT_W+2:0] w_dec;
        logic [MAX_CNT_W+2:0] w_p;
        w_ext = {3'b000, base};
        w_dec = {3'b000, base >> 3} * (MAX_CNT_W+3)'(lvl);
        w_p   = w_ext - w_dec;
        if (base == '0)
            return '0;
        else if (w_p == '0 || w_p[MAX_CNT_W+2:MAX_CNT_W] != 3'b000)
            return MAX_CNT_W'(1);
        else
            return w_p[MAX_CNT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_tick_scheduler_tick_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tick_channel
//  Brief    : Period counter emitting a registered one-cycle enable.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_channel #(
    parameter int CNT_W = 26
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // ">=" lets a shrinking period catch up within one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (en && period != '0) begin
            if (r_cnt >= period - CNT_W'(1)) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            if (period == '0)
                r_cnt <= '0;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/game_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : game_tick_scheduler
//  Brief    : Game state sequencer producing per-object tick enables, a
//             game-second pulse, score seconds and difficulty level.
//  Revision : 1.0 - initial release
// ============================================================================
module game_tick_scheduler
    import game_tick_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 26,
    parameter int SEC_PERIOD    = 50000000,
    parameter int LEVEL_UP_SECS = 10,
    parameter int MAX_LEVEL     = 7
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    hit,
    input  logic [NUM_CH*CNT_W-1:0] base_period,
    output logic [NUM_CH-1:0]       tick,
    output logic                    sec_tick,
    output logic [7:0]              seconds,
    output logic [2:0]              level,
    output logic [1:0]              state,
    output logic                    game_over
);

    localparam logic [CNT_W-1:0]   c_sec_period = CNT_W'(SEC_PERIOD);
    localparam logic [LEVEL_W-1:0] c_max_level  = LEVEL_W'(MAX_LEVEL);
    localparam logic [7:0]         c_lvl_secs   = 8'(LEVEL_UP_SECS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_clr;
    logic                 w_en;
    logic [7:0]           r_seconds;
    logic [LEVEL_W-1:0]   r_level;
    logic [7:0]           w_sec_nxt;
    logic                 w_lvl_up;
    logic [CNT_W-1:0]     w_period [NUM_CH+1];
    logic [NUM_CH:0]      w_ticks;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Priority hit > start > pause, with per-state masking of ignored inputs.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_clr       = 1'b1;
                end
            end
            ST_RUN: begin
                if (hit)
                    w_state_nxt = ST_OVER;
                else if (pause)
                    w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_clr       = 1'b1;
                end else if (pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_OVER: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_clr       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_en = (r_state == ST_RUN);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_period
        assign w_period[g] = CNT_W'(eff_period(MAX_CNT_W'(base_period[g*CNT_W +: CNT_W]), r_level));
    end
    assign w_period[NUM_CH] = c_sec_period;

    // Last instance is the game-second timer.
    for (genvar g = 0; g <= NUM_CH; g++) begin : g_chan
        tick_channel #(
            .CNT_W (CNT_W)
        ) u_chan (
            .CLK    (CLK),
            .RST    (RST),
            .en     (w_en),
            .clr    (w_clr),
            .period (w_period[g]),
            .tick   (w_ticks[g])
        );
    end

    always_comb begin
        w_sec_nxt = (r_seconds == 8'hFF) ? 8'hFF : r_seconds + 8'd1;
        w_lvl_up  = (w_sec_nxt != 8'd0) && ((w_sec_nxt % c_lvl_secs) == 8'd0);
    end

    // A completed second is credited even if the game stopped on that edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_seconds <= 8'd0;
            r_level   <= '0;
        end else if (w_clr) begin
            r_seconds <= 8'd0;
            r_level   <= '0;
        end else if (w_ticks[NUM_CH]) begin
            r_seconds <= w_sec_nxt;
            if (w_lvl_up && r_level < c_max_level)
                r_level <= r_level + LEVEL_W'(1);
        end
    end

    assign tick      = w_ticks[NUM_CH-1:0];
    assign sec_tick  = w_ticks[NUM_CH];
    assign seconds   = r_seconds;
    assign level     = r_level;
    assign state     = r_state;
    assign game_over = (r_state == ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_game_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_tick_scheduler
//  Brief    : Directed self-checking bench for game_tick_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 26;

    logic                    CLK;
    logic                    RST;
    logic                    start;
    logic                    pause;
    logic                    hit;
    logic [NUM_CH*CNT_W-1:0] base_period;
    logic [NUM_CH-1:0]       tick;
    logic                    sec_tick;
    logic [7:0]              seconds;
    logic [2:0]              level;
    logic [1:0]              state;
    logic                    game_over;

    int n_vec;
    int n_err;
    int cyc;

    game_tick_scheduler #(
        .NUM_CH        (NUM_CH),
        .CNT_W         (CNT_W),
        .SEC_PERIOD    (10),
        .LEVEL_UP_SECS (2),
        .MAX_LEVEL     (7)
    ) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .pause       (pause),
        .hit         (hit),
        .base_period (base_period),
        .tick        (tick),
        .sec_tick    (sec_tick),
        .seconds     (seconds),
        .level       (level),
        .state       (state),
        .game_over   (game_over)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    initial begin
        int f0, f1, f2cnt, f3cnt, nsec, t0b, t1b, n0sat;
        int quiet, r0, rsec, over_ticks, f0r;

        n_vec = 0; n_err = 0; cyc = 0;
        RST = 1'b1; start = 1'b0; pause = 1'b0; hit = 1'b0;
        base_period = {26'd3, 26'd0, 26'd16, 26'd8};
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_state", 32'(state), 0);
        check_val("rst_tick", 32'({tick, sec_tick, game_over}), 0);
        check_val("rst_score", 32'({seconds, level}), 0);
        RST = 1'b0;
        step();
        check_val("idle_hold", 32'(state), 0);

        // Scenario A: free run from start through level and seconds saturation
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        check_val("start_run", 32'(state), 1);
        f0 = -1; f1 = -1; f2cnt = 0; f3cnt = 0; nsec = 0; t0b = -1; t1b = -1; n0sat = 0;
        for (int c = 1; c <= 2575; c++) begin
            step();
            if (cyc == 10 || cyc == 20) check_val("sec_tick_at", 32'(sec_tick), 1);
            if (cyc <= 20) nsec += int'(sec_tick);
            if (tick[0] && f0 < 0) f0 = cyc;
            if (tick[1] && f1 < 0) f1 = cyc;
            if (tick[2]) f2cnt++;
            if (cyc <= 165 && tick[3]) f3cnt++;
            if (cyc > 16 && tick[0] && t0b < 0) t0b = cyc;
            if (cyc > 16 && tick[1] && t1b < 0) t1b = cyc;
            if (cyc >= 143 && cyc <= 150) n0sat += int'(tick[0]);
            if (cyc == 22) begin
                check_val("seconds_22", 32'(seconds), 2);
                check_val("level_22", 32'(level), 1);
            end
            if (cyc == 165) begin
                check_val("seconds_165", 32'(seconds), 16);
                check_val("level_165", 32'(level), 7);
            end
        end
        check_val("first_tick0", f0, 8);
        check_val("first_tick1", f1, 16);
        check_val("sec_cnt_20", nsec, 2);
        check_val("tick0_p7", t0b, 23);
        check_val("tick1_p14", t1b, 30);
        check_val("tick2_off", f2cnt, 0);
        check_val("tick3_cnt", f3cnt, 55);
        check_val("tick0_p1", n0sat, 8);
        check_val("seconds_sat", 32'(seconds), 255);
        check_val("level_sat", 32'(level), 7);

        // Scenario B: pause/resume, hit, restart, async reset
        RST = 1'b1;
        step();
        RST = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        quiet = 0; r0 = -1; rsec = -1; over_ticks = 0; f0r = -1;
        for (int c = 1; c <= 55; c++) begin
            step();
            if (cyc >= 6 && cyc <= 25 && (tick != '0 || sec_tick)) quiet++;
            if (cyc > 25 && cyc < 32 && tick[0] && r0 < 0) r0 = cyc;
            if (cyc > 25 && cyc < 32 && sec_tick && rsec < 0) rsec = cyc;
            if (cyc >= 33 && cyc <= 40 && (tick != '0 || sec_tick)) over_ticks++;
            if (cyc > 40 && tick[0] && f0r < 0) f0r = cyc;
            case (cyc)
                4:  pause = 1'b1;
                5:  pause = 1'b0;
                10: check_val("paused", 32'(state), 2);
                24: pause = 1'b1;
                25: pause = 1'b0;
                26: check_val("resumed", 32'(state), 1);
                31: hit = 1'b1;
                32: begin
                    hit = 1'b0;
                    check_val("hit_tick3", 32'(tick[3]), 1);
                    check_val("hit_state", 32'(state), 3);
                    check_val("game_over", 32'(game_over), 1);
                end
                34: hit = 1'b1;
                35: begin
                    hit = 1'b0;
                    pause = 1'b1;
                end
                36: pause = 1'b0;
                39: begin
                    check_val("over_hold", 32'(state), 3);
                    check_val("over_secs", 32'(seconds), 1);
                    start = 1'b1;
                end
                40: begin
                    start = 1'b0;
                    check_val("restart_st", 32'(state), 1);
                    check_val("restart_sc", 32'({seconds, level}), 0);
                end
                43: start = 1'b1;
                44: start = 1'b0;
                55: begin
                    check_val("pre_rst_t3", 32'(tick[3]), 1);
                    check_val("pre_rst_sec", 32'(seconds), 1);
                end
                default: ;
            endcase
        end
        check_val("pause_quiet", quiet, 0);
        check_val("resume_t0", r0, 28);
        check_val("resume_sec", rsec, 30);
        check_val("over_quiet", over_ticks, 0);
        check_val("restart_t0", f0r, 48);

        #2;
        RST = 1'b1;
        #1;
        check_val("arst_state", 32'(state), 0);
        check_val("arst_outs", 32'({tick, sec_tick, game_over}), 0);
        check_val("arst_score", 32'({seconds, level}), 0);
        RST = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
